ex_muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, consuming the operands, funct3 and M-extension decode held by the ID/EX pipeline register. While an operation is in progress it asserts `stall`, which the hazard logic ORs into the ID/EX and upstream hold (`dontUpdate`). The ID/EX register therefore keeps the instruction in EX until `done`. The result is muxed onto the EX result path in the `done` cycle.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/ex_muldiv_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the execute-stage RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam int unsigned MULDIV_ITERS = 32;
   localparam logic [4:0]  LAST_ITER    = 5'(MULDIV_ITERS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage. One bit per cycle
// over a shared 64-bit working register; stalls the front of the pipe until done.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] lhs,
   input  logic [XLEN-1:0] rhs,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int W2 = 2 * XLEN;

   state_t          state_r, stateNext_s;
   logic [4:0]      cnt_r;
   logic [W2-1:0]   acc_r;
   logic [XLEN-1:0] opnd_r;
   logic [2:0]      op_r;
   logic            negRes_r;
   logic            done_r;
   logic [XLEN-1:0] result_r;

   logic            isDiv_s, lhsSigned_s, rhsSigned_s, lhsNeg_s, rhsNeg_s, negStart_s;
   logic [XLEN-1:0] lhsMag_s, rhsMag_s, specialRes_s, finalRes_s, quot_s, rem_s;
   logic            divZero_s, overflow_s, special_s, geq_s;
   logic [XLEN:0]   mulSum_s;
   logic [XLEN-1:0] divSub_s;
   logic [W2-1:0]   iterNext_s, prod_s;

   // Operand decode at accept: signedness, magnitudes, result sign and special cases.
   always_comb begin
      isDiv_s      = funct3[2];
      lhsSigned_s  = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
      rhsSigned_s  = lhsSigned_s && (funct3 != F3_MULHSU);
      lhsNeg_s     = lhsSigned_s & lhs[XLEN-1];
      rhsNeg_s     = rhsSigned_s & rhs[XLEN-1];
      lhsMag_s     = lhsNeg_s ? -lhs : lhs;
      rhsMag_s     = rhsNeg_s ? -rhs : rhs;
      // Remainder takes the dividend's sign; everything else the XOR of both.
      negStart_s   = (funct3 == F3_REM) ? lhsNeg_s : (lhsNeg_s ^ rhsNeg_s);
      divZero_s    = isDiv_s && (rhs == {XLEN{1'b0}});
      overflow_s   = isDiv_s && lhsSigned_s && (lhs == {1'b1, {(XLEN-1){1'b0}}})
                     && (rhs == {XLEN{1'b1}});
      special_s    = divZero_s | overflow_s;
      if (divZero_s) begin
         specialRes_s = funct3[1] ? lhs : {XLEN{1'b1}};
      end else if (overflow_s) begin
         specialRes_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         specialRes_s = {XLEN{1'b0}};
      end
   end

   // One iteration of shift-add multiply or restoring divide, plus final sign fix-up.
   always_comb begin
      mulSum_s   = {1'b0, acc_r[W2-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
      geq_s      = acc_r[W2-1:XLEN-1] >= {1'b0, opnd_r};
      divSub_s   = acc_r[W2-2:XLEN-1] - opnd_r;
      if (op_r[2]) begin
         iterNext_s = geq_s ? {divSub_s, acc_r[XLEN-2:0], 1'b1} : {acc_r[W2-2:0], 1'b0};
      end else begin
         iterNext_s = {mulSum_s, acc_r[XLEN-1:1]};
      end
      prod_s = negRes_r ? -iterNext_s : iterNext_s;
      quot_s = negRes_r ? -iterNext_s[XLEN-1:0] : iterNext_s[XLEN-1:0];
      rem_s  = negRes_r ? -iterNext_s[W2-1:XLEN] : iterNext_s[W2-1:XLEN];
      case (op_r)
         F3_MUL:                      finalRes_s = prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: finalRes_s = prod_s[W2-1:XLEN];
         F3_DIV, F3_DIVU:             finalRes_s = quot_s;
         F3_REM, F3_REMU:             finalRes_s = rem_s;
         default:                     finalRes_s = quot_s;
      endcase
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      stateNext_s = state_r;
      if (flush) begin
         stateNext_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    stateNext_s = start ? (special_s ? DONE : RUN) : IDLE;
            RUN:     stateNext_s = (cnt_r == LAST_ITER) ? DONE : RUN;
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
         endcase
      end
   end

   // State, working registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= 5'd0;
         acc_r    <= {W2{1'b0}};
         opnd_r   <= {XLEN{1'b0}};
         op_r     <= 3'b000;
         negRes_r <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {XLEN{1'b0}};
      end else begin
         state_r <= stateNext_s;
         done_r  <= (stateNext_s == DONE);
         if (flush) begin
            cnt_r <= 5'd0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     op_r     <= funct3;
                     negRes_r <= negStart_s;
                     cnt_r    <= 5'd0;
                     if (special_s) begin
                        result_r <= specialRes_s;
                     end else begin
                        opnd_r <= isDiv_s ? rhsMag_s : lhsMag_s;
                        acc_r  <= {{XLEN{1'b0}}, (isDiv_s ? lhsMag_s : rhsMag_s)};
                     end
                  end
               end
               RUN: begin
                  acc_r <= iterNext_s;
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == LAST_ITER) begin
                     result_r <= finalRes_s;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign stall  = start & ~done_r & ~flush;
   assign done   = done_r;
   assign result = result_r;

endmodule
